// File: rtl/mem_io_pkg.sv
// Shared definitions for the byte-stream memory reader.
//   BYTE_W    : width of one byte lane (8)
//   WORD_W    : width of one memory word (32)
//   LANES     : byte lanes per word
//   rd_state_e: reader FSM state encodings
package mem_io_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / BYTE_W;
    localparam int OFS_W  = $clog2(LANES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } rd_state_e;

endpackage

// File: rtl/byte_lane_select.sv
// Combinational little-endian byte lane picker.
//   word   : 32-bit buffered word
//   offset : byte offset within the word (0 = bits 7:0)
//   data   : selected byte
module byte_lane_select
    import mem_io_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [OFS_W-1:0]  offset,
    output logic [BYTE_W-1:0] data
);

    logic [LANES-1:0][BYTE_W-1:0] lane;

    // Lane i holds bits [8*i+7 : 8*i], so the packed view is little-endian.
    genvar i;
    generate
        for (i = 0; i < LANES; i++) begin : g_lane
            assign lane[i] = word[i*BYTE_W +: BYTE_W];
        end
    endgenerate

    assign data = lane[offset];

endmodule

// File: rtl/mem_byte_reader.sv
// Streams byte_count_in bytes starting at start_addr_in out of a 32-bit
// word memory, one word read per group of up to four bytes.
//   clk, rst_n        : clock, async active-low reset
//   start_in          : request pulse (only honoured while idle)
//   start_addr_in     : first byte address
//   byte_count_in     : bytes to emit, 0..2^BYTE_ADDR_WIDTH
//   busy_out          : not idle
//   done_out          : one-cycle completion pulse
//   word_addr_out     : word address to memory (valid with rd strobe)
//   word_rd_en_out    : one-cycle read strobe; data returns next cycle
//   word_data_in      : memory read data
//   byte_data_out     : current byte
//   byte_valid_out    : byte_data_out valid
//   byte_ready_in     : consumer accepts the current byte
module mem_byte_reader
    import mem_io_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_in,
    input  logic [BYTE_ADDR_WIDTH-1:0] start_addr_in,
    input  logic [BYTE_ADDR_WIDTH:0]   byte_count_in,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [BYTE_ADDR_WIDTH-3:0] word_addr_out,
    output logic                       word_rd_en_out,
    input  logic [WORD_W-1:0]          word_data_in,
    output logic [BYTE_W-1:0]          byte_data_out,
    output logic                       byte_valid_out,
    input  logic                       byte_ready_in
);

    localparam int AW = BYTE_ADDR_WIDTH;

    rd_state_e         state_q, state_d;
    logic [AW-1:0]     addr_q;
    logic [AW:0]       cnt_q;
    logic [WORD_W-1:0] buf_q;
    logic [BYTE_W-1:0] lane_byte;
    logic              load, xfer;

    assign load = (state_q == ST_IDLE) && start_in;
    assign xfer = (state_q == ST_SEND) && byte_ready_in;

    byte_lane_select u_lane (
        .word   (buf_q),
        .offset (addr_q[OFS_W-1:0]),
        .data   (lane_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                addr_q <= start_addr_in;
                cnt_q  <= byte_count_in;
            end else if (xfer) begin
                // Address wraps naturally; the count alone ends the stream.
                addr_q <= addr_q + AW'(1);
                cnt_q  <= cnt_q - (AW+1)'(1);
            end
            if (state_q == ST_WAIT)
                buf_q <= word_data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_in)
                         state_d = (byte_count_in == '0) ? ST_DONE : ST_READ;
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_SEND;
            ST_SEND: if (byte_ready_in) begin
                         if (cnt_q == (AW+1)'(1))
                             state_d = ST_DONE;
                         else if (addr_q[OFS_W-1:0] == OFS_W'(LANES-1))
                             state_d = ST_READ;
                     end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state register alone, so asserting reset
    // clears them immediately. Data/address buses are gated to zero outside
    // the state that qualifies them.
    always_comb begin
        busy_out       = (state_q != ST_IDLE);
        done_out       = (state_q == ST_DONE);
        word_rd_en_out = (state_q == ST_READ);
        byte_valid_out = (state_q == ST_SEND);
        word_addr_out  = '0;
        byte_data_out  = '0;
        if (word_rd_en_out)
            word_addr_out = addr_q[AW-1:OFS_W];
        if (byte_valid_out)
            byte_data_out = lane_byte;
    end

endmodule

// File: doc/mem_byte_reader.md
MEM_BYTE_READER -- requirements
Module: mem_byte_reader

Interface
REQ-001 SHALL have parameter BYTE_ADDR_WIDTH, default 6, giving the byte-level address width (64 bytes).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset is asynchronous and active-low.
REQ-004 SHALL have port start_in, input, 1: request pulse, sampled only in IDLE.
REQ-005 SHALL have port start_addr_in, input, BYTE_ADDR_WIDTH: first byte address, latched on accepted start.
REQ-006 SHALL have port byte_count_in, input, BYTE_ADDR_WIDTH+1: number of bytes to emit, 0..2^BYTE_ADDR_WIDTH, latched on accepted start.
REQ-007 SHALL have port busy_out, output, 1: high in every state except IDLE.
REQ-008 SHALL have port done_out, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port word_addr_out, output, BYTE_ADDR_WIDTH-2: word address to memory.
REQ-010 SHALL have port word_rd_en_out, output, 1: one-cycle word read strobe.
REQ-011 SHALL have port word_data_in, input, 32: read data, valid in the cycle after word_rd_en_out.
REQ-012 SHALL have port byte_data_out, output, 8: current byte, little-endian lane of the buffered word.
REQ-013 SHALL have port byte_valid_out, output, 1: byte_data_out is valid.
REQ-014 SHALL have port byte_ready_in, input, 1: consumer accepts; transfer when valid and ready are both high.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WAIT, SEND, DONE.
REQ-016 IDLE with start_in=1 SHALL latch address and count, then go to DONE if count=0, otherwise to READ.
REQ-017 READ SHALL assert word_rd_en_out for exactly one cycle with word_addr_out=addr[W-1:2], then go to WAIT.
REQ-018 WAIT SHALL capture word_data_in into a 32-bit buffer, then go to SEND.
REQ-019 SEND SHALL drive byte_valid_out=1 and byte_data_out=buffer[8*addr[1:0]+7 : 8*addr[1:0]].
REQ-020 On transfer in SEND: address +1 modulo 2^BYTE_ADDR_WIDTH and count -1; next state DONE if count was 1, READ if addr[1:0] was 3, otherwise stay in SEND.
REQ-021 Without transfer, byte_valid_out and byte_data_out SHALL hold stable (no retraction).
REQ-022 DONE SHALL assert done_out for one cycle, then return to IDLE.
REQ-023 start_in outside IDLE SHALL be ignored.
REQ-024 Address wrap from 2^W-1 to 0 SHALL re-read word 0; the count limits the stream, not the address.
REQ-025 Latency: first byte_valid_out SHALL be 3 cycles after the start cycle; each further word costs 2 bubble cycles.
REQ-026 word_rd_en_out SHALL never assert outside READ; byte_valid_out SHALL never assert outside SEND.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and drive busy_out, done_out, word_rd_en_out, byte_valid_out, word_addr_out and byte_data_out to 0.
REQ-028 Reset mid-operation SHALL abandon the stream with no done_out pulse; after release, IDLE SHALL accept a new start.

Structure
REQ-029 FSM state encodings SHALL reside in the shared package or header mem_io_pkg, alongside the byte-lane width constant 8.
REQ-030 Lane extraction SHALL be a combinational sub-module byte_lane_select (32-bit word + 2-bit offset -> 8-bit byte); all other logic SHALL be in the top module.

Verification
Memory model: word0=0x44332211, word1=0x88776655, word15=0xDDCCBBAA; W=6.
REQ-031 start addr=0, count=4, ready=1 -> bytes 11,22,33,44; one read at word 0; done_out on the cycle after the last transfer.
REQ-032 addr=2, count=4 -> bytes 33,44,55,66; reads of word 0 then word 1; 2 bubble cycles between 44 and 55.
REQ-033 count=0 -> done_out one cycle after start; no word_rd_en_out and no byte_valid_out.
REQ-034 addr=0, count=2, ready low for 5 cycles at the first byte -> valid held with data 0x11 stable; then bytes 11,22.
REQ-035 addr=63, count=2 -> byte 0xDD from word 15, then byte 0x11 from word 0 (wrap).
REQ-036 rst_n low during SEND -> all outputs 0 at once with no done_out; start pulsed while busy is ignored; a new start after reset completes normally.
